// File: rtl/evm_vote_tally.sv
// evm_vote_tally
//   Vote capture and BCD tally block feeding the four-digit seven-segment
//   display driver of the EVM.
//
//   A rising edge on exactly one candidate button, while in voting mode and
//   idle, adds one vote to that candidate and to the running total. The vote
//   LED is then held for LOCK_CYCLES clocks, during which every button is
//   ignored. The ballot re-arms only after all buttons are released.
//   Simultaneous presses are rejected and also wait for a full release.
//
// Ports
//   clk_100MHz   : system clock
//   reset        : synchronous, active-high reset
//   vote_btn     : candidate buttons, debounced and synchronised, bit i = cand i
//   result_mode  : 0 = show total, 1 = show the candidate chosen by view_sel
//   view_sel     : candidate index shown in result mode
//   ones..thousands : registered BCD digits of the displayed tally
//   vote_led     : high for LOCK_CYCLES clocks after an accepted vote
//   busy         : high whenever the ballot FSM is not idle
module evm_vote_tally #(
  parameter int unsigned LOCK_CYCLES = 100000000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] vote_btn,
  input  logic       result_mode,
  input  logic [1:0] view_sel,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic       vote_led,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOCKOUT,
    WAIT_REL
  } state_t;

  // The counter only ever holds LOCK_CYCLES-1 down to 0.
  localparam int unsigned CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          led_q, led_d;
  logic [3:0]    btn_prev_q;
  logic [15:0]   cand_q [4];
  logic [15:0]   cand_d [4];
  logic [15:0]   total_q, total_d;
  logic [15:0]   disp_q, disp_d;

  logic [3:0]    rise;
  logic          multi_rise;
  logic          single_rise;

  // Four-digit BCD increment with ripple carry; 9999 saturates.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign rise        = vote_btn & ~btn_prev_q;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_rise  = |(rise & (rise - 4'd1));
  assign single_rise = (rise != 4'd0) && !multi_rise;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    cand_d  = cand_q;
    total_d = total_q;

    case (state_q)
      IDLE: begin
        if (!result_mode) begin
          if (single_rise) begin
            for (int unsigned i = 0; i < 4; i++) begin
              if (rise[i]) begin
                cand_d[i] = bcd_inc(cand_q[i]);
              end
            end
            total_d = bcd_inc(total_q);
            cnt_d   = LOCK_LOAD;
            led_d   = 1'b1;
            state_d = LOCKOUT;
          end else if (multi_rise) begin
            state_d = WAIT_REL;
          end
        end
      end
      LOCKOUT: begin
        if (cnt_q == '0) begin
          led_d   = 1'b0;
          state_d = WAIT_REL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_REL: begin
        if (vote_btn == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    disp_d = result_mode ? cand_q[view_sel] : total_q;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      led_q      <= 1'b0;
      // All-ones so a button held through reset never looks like a new press.
      btn_prev_q <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        cand_q[i] <= '0;
      end
      total_q    <= '0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
      btn_prev_q <= vote_btn;
      for (int unsigned i = 0; i < 4; i++) begin
        cand_q[i] <= cand_d[i];
      end
      total_q    <= total_d;
      disp_q     <= disp_d;
    end
  end

  assign ones      = disp_q[3:0];
  assign tens      = disp_q[7:4];
  assign hundreds  = disp_q[11:8];
  assign thousands = disp_q[15:12];
  assign vote_led  = led_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_evm_vote_tally.sv
module tb_evm_vote_tally;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic       rm;
  logic [1:0] vs;
  logic [3:0] ones, tens, hundreds, thousands;
  logic       led;
  logic       busy;
  logic [15:0] disp;

  int checks = 0;
  int errors = 0;
  int lc;

  evm_vote_tally #(.LOCK_CYCLES(4)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .vote_btn   (btn),
    .result_mode(rm),
    .view_sel   (vs),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .thousands  (thousands),
    .vote_led   (led),
    .busy       (busy)
  );

  assign disp = {thousands, hundreds, tens, ones};

  always #5 clk = ~clk;

  // Advance one rising edge, return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One press of candidate idx; returns how many sampled cycles had vote_led high.
  // Ends after the FSM has returned to IDLE (E4 -> WAIT_REL, E5 -> IDLE).
  task automatic vote(input int idx, output int leds);
    btn = 4'b0001 << idx;
    tick();
    leds = int'(led);
    btn = 4'b0000;
    repeat (5) begin
      tick();
      leds += int'(led);
    end
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    btn   = 4'b0001;
    rm    = 1'b0;
    vs    = 2'd0;
    tick();
    tick();
    chk("rst_disp", disp, 16'h0000);
    chk("rst_led", led, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Button held through reset must not count.
    reset = 1'b0;
    repeat (3) tick();
    chk("held_disp", disp, 16'h0000);
    chk("held_busy", busy, 1'b0);

    // Fresh press on cand0: tally edge, then display edge.
    btn = 4'b0000;
    tick();
    btn = 4'b0001;
    tick();
    chk("acc_led", led, 1'b1);
    chk("acc_busy", busy, 1'b1);
    chk("acc_disp_lag", disp, 16'h0000);
    lc  = 1;
    btn = 4'b0000;
    tick();
    chk("acc_disp", disp, 16'h0001);
    lc += int'(led);
    repeat (6) begin
      tick();
      lc += int'(led);
    end
    chk("led_width", lc, 4);
    chk("idle_after_vote", busy, 1'b0);

    // cand2 press, re-press during lockout is ignored.
    btn = 4'b0100;
    tick();
    btn = 4'b0000;
    tick();
    btn = 4'b0100;
    tick();
    chk("lock_busy", busy, 1'b1);
    chk("lock_led", led, 1'b1);
    btn = 4'b0000;
    repeat (4) tick();
    chk("lock_idle", busy, 1'b0);
    chk("lock_total", disp, 16'h0002);
    vote(2, lc);
    chk("c2_second_led", lc, 4);
    chk("c2_total", disp, 16'h0003);
    rm = 1'b1;
    vs = 2'd2;
    tick();
    chk("view_c2", disp, 16'h0002);
    vs = 2'd0;
    tick();
    chk("view_c0", disp, 16'h0001);
    vs = 2'd3;
    tick();
    chk("view_c3", disp, 16'h0000);
    rm = 1'b0;
    tick();
    chk("view_total", disp, 16'h0003);

    // Simultaneous press is rejected and waits for full release.
    btn = 4'b0110;
    tick();
    chk("sim_busy0", busy, 1'b1);
    chk("sim_led", led, 1'b0);
    tick();
    chk("sim_busy1", busy, 1'b1);
    btn = 4'b0010;
    tick();
    chk("sim_busy2", busy, 1'b1);
    btn = 4'b0000;
    tick();
    chk("sim_rel", busy, 1'b0);
    chk("sim_total", disp, 16'h0003);
    rm = 1'b1;
    vs = 2'd1;
    tick();
    chk("sim_c1", disp, 16'h0000);
    vs = 2'd2;
    tick();
    chk("sim_c2", disp, 16'h0002);
    rm = 1'b0;
    tick();

    // Reset in the middle of a lockout with the button still held.
    btn = 4'b1000;
    tick();
    chk("mid_led", led, 1'b1);
    tick();
    chk("mid_total", disp, 16'h0004);
    reset = 1'b1;
    tick();
    chk("mid_rst_disp", disp, 16'h0000);
    chk("mid_rst_led", led, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (2) tick();
    chk("mid_held_busy", busy, 1'b0);
    chk("mid_held_led", led, 1'b0);
    btn = 4'b0000;
    tick();
    chk("mid_held_disp", disp, 16'h0000);
    rm = 1'b1;
    vs = 2'd3;
    tick();
    chk("mid_c3_zero", disp, 16'h0000);
    rm = 1'b0;
    vs = 2'd0;
    tick();

    // Carry chain and saturation: total runs one vote ahead of cand3.
    vote(0, lc);
    chk("sat_pre", disp, 16'h0001);
    for (int k = 1; k <= 9998; k++) begin
      vote(3, lc);
      if (k == 1)    chk("run_led", lc, 4);
      if (k == 8)    chk("run_0009", disp, 16'h0009);
      if (k == 9)    chk("run_0010", disp, 16'h0010);
      if (k == 98)   chk("run_0099", disp, 16'h0099);
      if (k == 99)   chk("run_0100", disp, 16'h0100);
      if (k == 998)  chk("run_0999", disp, 16'h0999);
      if (k == 999)  chk("run_1000", disp, 16'h1000);
      if (k == 9998) chk("run_9999", disp, 16'h9999);
    end
    rm = 1'b1;
    vs = 2'd3;
    tick();
    chk("c3_9998", disp, 16'h9998);
    rm = 1'b0;
    tick();

    // Total already saturated; cand3 reaches 9999.
    vote(3, lc);
    chk("tot_sat_led", lc, 4);
    chk("tot_sat", disp, 16'h9999);
    rm = 1'b1;
    tick();
    chk("c3_9999", disp, 16'h9999);
    rm = 1'b0;
    tick();

    // Both saturated: vote still accepted with full lockout.
    vote(3, lc);
    chk("both_sat_led", lc, 4);
    chk("both_sat_tot", disp, 16'h9999);
    rm = 1'b1;
    tick();
    chk("both_sat_c3", disp, 16'h9999);
    vs = 2'd0;
    tick();
    chk("both_sat_c0", disp, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/evm_vote_tally.md
Name: evm_vote_tally

Overview:
- Upstream of the four-digit multiplexed seven-segment driver in the EVM design.
- Captures one-hot candidate vote buttons and enforces one vote per press with a post-vote lockout.
- Keeps per-candidate and total 4-digit BCD tallies.
- Presents the selected tally as ones/tens/hundreds/thousands BCD nibbles, which feed the display driver directly.

Parameters:
- LOCK_CYCLES, 100000000, clock cycles vote_led stays high and the ballot stays locked after an accepted vote (1 s at 100 MHz); legal range >= 1.

Ports:
- clk_100MHz  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- vote_btn  input  4  candidate buttons, already debounced and synchronised, active high; bit i = candidate i.
- result_mode  input  1  0 = voting (display total), 1 = result (display candidate selected by view_sel).
- view_sel  input  2  candidate index shown when result_mode = 1.
- ones  output  4  BCD ones digit of the displayed value.
- tens  output  4  BCD tens digit.
- hundreds  output  4  BCD hundreds digit.
- thousands  output  4  BCD thousands digit.
- vote_led  output  1  high during lockout after an accepted vote.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (sampled on clk edge)
  - All 5 tallies (cand0..3, total) = 0000.
  - ones/tens/hundreds/thousands = 0, vote_led = 0, busy = 0, state = IDLE.
  - btn_prev = 4'b1111, so buttons held through reset never count.
  - Reset wins over every other event in the same cycle.
- Edge detect: rise = vote_btn & ~btn_prev; btn_prev <= vote_btn every non-reset cycle, in all states and both modes.
- FSM states: IDLE, LOCKOUT, WAIT_REL.
  - IDLE, result_mode = 0, rise is one-hot:
    - Increment cand[idx] and total in the same edge.
    - Load lock counter with LOCK_CYCLES-1, go to LOCKOUT, vote_led <= 1.
  - IDLE, result_mode = 0, rise has >= 2 bits set (simultaneous press):
    - Reject: no tally change, no vote_led, go to WAIT_REL.
  - IDLE, result_mode = 1: rises ignored, stay IDLE.
  - LOCKOUT:
    - Counter decrements each cycle; all buttons ignored.
    - At counter = 0: vote_led <= 0, go to WAIT_REL.
    - vote_led is high exactly LOCK_CYCLES cycles.
  - WAIT_REL: go to IDLE on the first cycle vote_btn == 0.
  - A result_mode change in any state does not abort LOCKOUT or WAIT_REL.
- BCD arithmetic
  - Each tally is 4 BCD digits.
  - Increment ripples: a digit at 9 becomes 0 and carries, all within one cycle.
  - Saturates at 9999: incrementing 9999 holds 9999 (no wrap).
  - Candidate and total saturate independently; the vote is still "accepted" (lockout occurs).
  - No digit ever holds a value > 9.
- Display outputs
  - Registered.
  - Source = total if result_mode = 0, else cand[view_sel].
  - Outputs reflect source state one cycle after any tally, result_mode or view_sel change.
  - An accepted vote shows on the outputs 2 cycles after the rising button edge (tally edge + output edge).
- busy = (state != IDLE), combinational from the state register.

Test Plan:
- Reset with vote_btn = 4'b0001 held, then release, then press bit0 (LOCK_CYCLES = 4)
  - Held press counts 0; the new press makes total = 0001.
  - Outputs ones = 1, others 0, 2 cycles after the edge.
  - vote_led high exactly 4 cycles.
- Press cand2 while vote_led = 1, then again after release
  - Lockout press ignored; after WAIT_REL→IDLE, the second press counts.
  - result_mode = 1, view_sel = 2 shows 0002 (or 0001 if only one valid press).
- vote_btn = 4'b0110 rising in the same cycle
  - No tally change, vote_led stays 0, busy = 1 until buttons = 0.
- Preload via 9 votes then 1 more on cand1
  - Total goes 0009→0010: ones = 0, tens = 1 (carry).
  - Extend run to 0999→1000 and check the three-digit carry.
- Force cand3/total to 9999 via 9999 votes (or a forced tally), then vote cand3
  - Both stay 9999, vote_led still pulses 4 cycles.
- Reset asserted mid-LOCKOUT with tallies nonzero
  - Next cycle: all outputs 0, vote_led = 0, busy = 0.
  - A button held across reset does not count.
